// File: rtl/sample_framer_pkg.sv
// Shared constants and state encoding for the sampler -> framer -> transmitter chain.
package sample_framer_pkg;

    localparam int               DEFAULT_DATA_SIZE = 8;
    localparam int               DEFAULT_FRAME_LEN = 1024;
    localparam int               DEFAULT_TIMEOUT   = 65535;
    localparam logic [7:0]       DEFAULT_HEADER    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        WAIT_VALID,
        SEND_DATA,
        REQ_NEXT,
        SEND_SUM,
        DONE
    } state_t;

    function automatic logic is_send_state(input state_t s);
        return (s == SEND_HDR) || (s == SEND_DATA) || (s == SEND_SUM);
    endfunction

endpackage

// File: rtl/sample_framer_edge_detect.sv
// Rising-edge detector: o_rise is high in the cycle i_sig is 1 after being 0.
module edge_detect (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_sig,
    output logic o_rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = i_sig;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_rise = i_sig & ~prev_q;

endmodule

// File: rtl/sample_framer.sv
// Frames FRAME_LEN sampler bytes as HEADER, samples, 8-bit additive checksum,
// handing each byte to a byte transmitter and pacing the sampler with o_next.
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int                   DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int                   FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter logic [DATA_SIZE-1:0] HEADER    = DATA_SIZE'(DEFAULT_HEADER),
    parameter int                   TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_idle,
    input  logic                 i_tx_done,
    output logic                 o_next,
    output logic [DATA_SIZE-1:0] o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_error
);

    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_SIZE-1:0] sum_q, sum_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 error_q, error_d;

    logic valid_rise;
    logic idle_rise;
    logic send_state;
    logic tx_accept;
    logic abort_now;

    edge_detect u_valid_edge (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_sig     (i_valid),
        .o_rise    (valid_rise)
    );

    edge_detect u_idle_edge (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_sig     (i_idle),
        .o_rise    (idle_rise)
    );

    // Phase 0 is the entry cycle, phase 1 launches the byte; i_tx_done counts only from phase 2.
    assign send_state = is_send_state(state_q);
    assign tx_accept  = send_state && (phase_q == 2'd2) && i_tx_done;
    assign abort_now  = abort_pend_q | idle_rise;

    always_comb begin
        state_d      = state_q;
        phase_d      = (phase_q == 2'd2) ? 2'd2 : phase_q + 2'd1;
        count_d      = count_q;
        sum_d        = sum_q;
        data_d       = data_q;
        timer_d      = timer_q;
        abort_pend_d = abort_pend_q;
        error_d      = 1'b0;

        if (send_state && idle_rise) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (i_start) begin
                    state_d = SEND_HDR;
                    count_d = '0;
                    sum_d   = '0;
                    timer_d = '0;
                end
            end
            SEND_HDR: begin
                if (tx_accept) begin
                    if (abort_now) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else begin
                        state_d = WAIT_VALID;
                        timer_d = '0;
                    end
                end
            end
            // A fresh sample beats a timeout landing in the same cycle.
            WAIT_VALID: begin
                if (idle_rise) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (valid_rise) begin
                    data_d  = i_data;
                    sum_d   = sum_q + i_data;
                    count_d = count_q + CW'(1);
                    state_d = SEND_DATA;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SEND_DATA: begin
                if (tx_accept) begin
                    if (abort_now) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else if (count_q == CW'(FRAME_LEN)) begin
                        state_d = SEND_SUM;
                    end else begin
                        state_d = REQ_NEXT;
                    end
                end
            end
            REQ_NEXT: begin
                if (idle_rise) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    state_d = WAIT_VALID;
                    timer_d = '0;
                end
            end
            SEND_SUM: begin
                if (tx_accept) begin
                    if (abort_now) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            phase_d = 2'd0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            phase_q      <= 2'd0;
            count_q      <= '0;
            sum_q        <= '0;
            data_q       <= '0;
            timer_q      <= '0;
            abort_pend_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            data_q       <= data_d;
            timer_q      <= timer_d;
            abort_pend_q <= abort_pend_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        o_tx_data = '0;
        case (state_q)
            SEND_HDR:  o_tx_data = HEADER;
            SEND_DATA: o_tx_data = data_q;
            SEND_SUM:  o_tx_data = sum_q;
            default:   o_tx_data = '0;
        endcase
    end

    assign o_tx_start   = send_state && (phase_q == 2'd1);
    assign o_busy       = (state_q != IDLE);
    assign o_next       = (state_q == REQ_NEXT);
    assign o_frame_done = (state_q == DONE);
    assign o_error      = error_q;

endmodule

// File: tb/tb_sample_framer.sv
// Self-checking bench for sample_framer: models a sampler and a byte transmitter
// and compares every transmitted frame with HEADER, samples and modular checksum.
module tb_sample_framer;

    localparam int         DW  = 8;
    localparam int         FL  = 4;
    localparam int         TO  = 100;
    localparam logic [7:0] HDR = 8'hA5;

    logic          i_clock = 1'b0;
    logic          i_reset_n;
    logic          i_start;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_idle;
    logic          i_tx_done;
    logic          o_next;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_start;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_error;

    int n_tests = 0;
    int n_fail  = 0;

    int         tx_cnt    = 0;
    int         done_cnt  = 0;
    int         next_cnt  = 0;
    int         fdone_cnt = 0;
    int         err_cnt   = 0;
    int         stab_err  = 0;
    logic [7:0] tx_q[$];
    logic       in_flight = 1'b0;
    logic [7:0] held      = 8'h00;

    sample_framer #(
        .DATA_SIZE (DW),
        .FRAME_LEN (FL),
        .HEADER    (HDR),
        .TIMEOUT   (TO)
    ) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_idle       (i_idle),
        .i_tx_done    (i_tx_done),
        .o_next       (o_next),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_error      (o_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(negedge i_clock);
        #1;
    endtask

    // Passive observer on the falling edge; everything else acts 1ns later.
    always @(negedge i_clock) begin
        if (!i_reset_n) begin
            in_flight = 1'b0;
        end else begin
            if (i_tx_done) begin
                done_cnt  = done_cnt + 1;
                in_flight = 1'b0;
            end else if (in_flight && (o_tx_data !== held)) begin
                stab_err = stab_err + 1;
            end
            if (o_tx_start) begin
                tx_cnt = tx_cnt + 1;
                tx_q.push_back(o_tx_data);
                in_flight = 1'b1;
                held      = o_tx_data;
            end
            if (o_next)       next_cnt  = next_cnt + 1;
            if (o_frame_done) fdone_cnt = fdone_cnt + 1;
            if (o_error)      err_cnt   = err_cnt + 1;
        end
    end

    // Byte transmitter model: completes each launched byte 1..5 cycles later.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            tick();
            if (o_tx_start) begin
                repeat ($urandom_range(1, 5)) tick();
                i_tx_done = 1'b1;
                tick();
                i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic reset_dut();
        i_start   = 1'b0;
        i_valid   = 1'b0;
        i_idle    = 1'b0;
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic wait_header(output bit timed_out);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < 50 && done_cnt == d0; c++) tick();
        timed_out = (done_cnt == d0);
    endtask

    task automatic drive_sample(input logic [7:0] d, input int hold);
        repeat ($urandom_range(1, 4)) tick();
        i_data  = d;
        i_valid = 1'b1;
        repeat (hold) tick();
        i_valid = 1'b0;
        i_data  = 8'($urandom);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_start   = 1'b1;
        i_valid   = 1'b0;
        i_idle    = 1'b0;
        i_data    = 8'h55;
        repeat (3) tick();
        n_tests++; if (o_busy !== 1'b0)       begin n_fail++; $display("[TB] FAIL reset o_busy: got %b expected 0", o_busy); end
        n_tests++; if (o_tx_start !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset o_tx_start: got %b expected 0", o_tx_start); end
        n_tests++; if (o_tx_data !== 8'h00)   begin n_fail++; $display("[TB] FAIL reset o_tx_data: got %h expected 00", o_tx_data); end
        n_tests++; if (o_next !== 1'b0)       begin n_fail++; $display("[TB] FAIL reset o_next: got %b expected 0", o_next); end
        n_tests++; if (o_frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset o_frame_done: got %b expected 0", o_frame_done); end
        n_tests++; if (o_error !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset o_error: got %b expected 0", o_error); end
        i_start = 1'b0;
        i_reset_n = 1'b1;
        repeat (4) tick();
    endtask

    // One complete frame; the expected byte stream is built from the samples directly.
    task automatic test_frame(input string name, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input int hold, input bit start_level);
        logic [7:0] smp[4];
        logic [7:0] exp_b[$];
        logic [7:0] act;
        int         sum;
        int         n0, f0, e0, st0;
        bit         to;
        smp = '{s0, s1, s2, s3};
        sum = 0;
        exp_b.push_back(HDR);
        for (int k = 0; k < FL; k++) begin
            exp_b.push_back(smp[k]);
            sum = sum + int'(smp[k]);
        end
        exp_b.push_back(8'(sum % 256));
        tx_q.delete();
        n0 = next_cnt; f0 = fdone_cnt; e0 = err_cnt; st0 = stab_err;

        i_start = 1'b1;
        tick();
        if (!start_level) i_start = 1'b0;
        wait_header(to);
        for (int k = 0; k < FL && !to; k++) begin
            drive_sample(smp[k], hold);
            if (k < FL - 1) begin
                for (int c = 0; c < 100 && next_cnt <= n0 + k; c++) tick();
                if (next_cnt <= n0 + k) to = 1'b1;
            end
        end
        for (int c = 0; c < 100 && fdone_cnt == f0 && !to; c++) tick();
        i_start = 1'b0;
        if (fdone_cnt == f0) to = 1'b1;
        repeat (6) tick();

        n_tests++; if (to) begin n_fail++; $display("[TB] FAIL %s progress: got stall expected complete frame", name); end
        n_tests++; if (tx_q.size() != exp_b.size()) begin n_fail++; $display("[TB] FAIL %s byte_count: got %0d expected %0d", name, tx_q.size(), exp_b.size()); end
        for (int k = 0; k < exp_b.size(); k++) begin
            act = (k < tx_q.size()) ? tx_q[k] : 8'hxx;
            n_tests++; if (act !== exp_b[k]) begin n_fail++; $display("[TB] FAIL %s byte%0d: got %h expected %h", name, k, act, exp_b[k]); end
        end
        n_tests++; if (next_cnt - n0 != FL - 1) begin n_fail++; $display("[TB] FAIL %s next_pulses: got %0d expected %0d", name, next_cnt - n0, FL - 1); end
        n_tests++; if (fdone_cnt - f0 != 1) begin n_fail++; $display("[TB] FAIL %s frame_done: got %0d expected 1", name, fdone_cnt - f0); end
        n_tests++; if (err_cnt - e0 != 0) begin n_fail++; $display("[TB] FAIL %s error_pulses: got %0d expected 0", name, err_cnt - e0); end
        n_tests++; if (stab_err - st0 != 0) begin n_fail++; $display("[TB] FAIL %s tx_data_stable: got %0d changes expected 0", name, stab_err - st0); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL %s busy_after: got %b expected 0", name, o_busy); end
    endtask

    task automatic test_timeout();
        int  cyc;
        int  e0;
        bit  to;
        reset_dut();
        tx_q.delete();
        e0 = err_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_header(to);
        cyc = 0;
        while (!o_error && cyc < TO + 20) begin
            tick();
            cyc++;
        end
        n_tests++; if (to) begin n_fail++; $display("[TB] FAIL timeout header: got stall expected header done"); end
        n_tests++; if (cyc != TO) begin n_fail++; $display("[TB] FAIL timeout cycle: got %0d expected %0d", cyc, TO); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout busy: got %b expected 0", o_busy); end
        tick();
        n_tests++; if (o_error !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout error_width: got %b expected 0", o_error); end
        n_tests++; if (err_cnt - e0 != 1) begin n_fail++; $display("[TB] FAIL timeout error_pulses: got %0d expected 1", err_cnt - e0); end
        n_tests++; if (tx_q.size() != 1) begin n_fail++; $display("[TB] FAIL timeout bytes: got %0d expected 1", tx_q.size()); end
    endtask

    task automatic test_idle_wait();
        int n0, f0, e0;
        bit to;
        reset_dut();
        tx_q.delete();
        n0 = next_cnt; f0 = fdone_cnt; e0 = err_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_header(to);
        for (int k = 0; k < 2 && !to; k++) begin
            drive_sample(8'($urandom), 2);
            for (int c = 0; c < 100 && next_cnt <= n0 + k; c++) tick();
            if (next_cnt <= n0 + k) to = 1'b1;
        end
        tick();
        i_idle = 1'b1;
        for (int c = 0; c < 20 && err_cnt == e0; c++) tick();
        i_idle = 1'b0;
        repeat (4) tick();
        n_tests++; if (to) begin n_fail++; $display("[TB] FAIL idle_wait progress: got stall expected two samples"); end
        n_tests++; if (err_cnt - e0 != 1) begin n_fail++; $display("[TB] FAIL idle_wait error: got %0d expected 1", err_cnt - e0); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_wait busy: got %b expected 0", o_busy); end
        n_tests++; if (tx_q.size() != 3) begin n_fail++; $display("[TB] FAIL idle_wait bytes: got %0d expected 3", tx_q.size()); end
        n_tests++; if (fdone_cnt - f0 != 0) begin n_fail++; $display("[TB] FAIL idle_wait frame_done: got %0d expected 0", fdone_cnt - f0); end
    endtask

    task automatic test_idle_send();
        int  n0, e0, d0, t0;
        bit  to;
        bit  early;
        reset_dut();
        tx_q.delete();
        n0 = next_cnt; e0 = err_cnt; d0 = done_cnt; t0 = tx_cnt;
        early = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_header(to);
        drive_sample(8'h3C, 1);
        for (int c = 0; c < 100 && next_cnt == n0; c++) tick();
        tick();
        i_data  = 8'h77;
        i_valid = 1'b1;
        for (int c = 0; c < 30 && tx_cnt < t0 + 3; c++) tick();
        i_idle  = 1'b1;
        i_valid = 1'b0;
        for (int c = 0; c < 30 && err_cnt == e0; c++) begin
            tick();
            if (err_cnt != e0 && done_cnt - d0 < 3) early = 1'b1;
        end
        i_idle = 1'b0;
        repeat (4) tick();
        n_tests++; if (err_cnt - e0 != 1) begin n_fail++; $display("[TB] FAIL idle_send error: got %0d expected 1", err_cnt - e0); end
        n_tests++; if (early) begin n_fail++; $display("[TB] FAIL idle_send order: got error before byte done expected after"); end
        n_tests++; if (tx_q.size() != 3) begin n_fail++; $display("[TB] FAIL idle_send bytes: got %0d expected 3", tx_q.size()); end
        n_tests++; if (next_cnt - n0 != 1) begin n_fail++; $display("[TB] FAIL idle_send next: got %0d expected 1", next_cnt - n0); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_send busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        int  n0, e0, f0, t0;
        bit  to;
        reset_dut();
        n0 = next_cnt; e0 = err_cnt; f0 = fdone_cnt; t0 = tx_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_header(to);
        drive_sample(8'h91, 1);
        for (int c = 0; c < 30 && tx_cnt < t0 + 2; c++) tick();
        i_reset_n = 1'b0;
        #1;
        n_tests++; if (o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_next !== 1'b0)
            begin n_fail++; $display("[TB] FAIL reset_mid ctrl: got busy=%b start=%b next=%b expected 0", o_busy, o_tx_start, o_next); end
        n_tests++; if (o_tx_data !== 8'h00 || o_frame_done !== 1'b0 || o_error !== 1'b0)
            begin n_fail++; $display("[TB] FAIL reset_mid data: got data=%h done=%b err=%b expected 0", o_tx_data, o_frame_done, o_error); end
        repeat (2) tick();
        i_reset_n = 1'b1;
        repeat (20) tick();
        n_tests++; if (err_cnt - e0 != 0) begin n_fail++; $display("[TB] FAIL reset_mid error: got %0d expected 0", err_cnt - e0); end
        n_tests++; if (fdone_cnt - f0 != 0) begin n_fail++; $display("[TB] FAIL reset_mid frame_done: got %0d expected 0", fdone_cnt - f0); end
        n_tests++; if (next_cnt - n0 != 0) begin n_fail++; $display("[TB] FAIL reset_mid next: got %0d expected 0", next_cnt - n0); end
        test_frame("after_reset", 8'h01, 8'h80, 8'h7F, 8'hC3, 3, 1'b0);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_start   = 1'b0;
        i_valid   = 1'b0;
        i_idle    = 1'b0;
        i_data    = 8'h00;
        test_reset();
        reset_dut();
        test_frame("basic", 8'd10, 8'd20, 8'd30, 8'd40, 1, 1'b0);
        reset_dut();
        test_frame("level_valid4", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4, 1'b0);
        reset_dut();
        test_frame("level_valid8", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8, 1'b0);
        reset_dut();
        test_frame("checksum_wrap", 8'hFF, 8'hFF, 8'h02, 8'h01, 2, 1'b0);
        reset_dut();
        test_frame("start_level", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3, 1'b1);
        for (int r = 0; r < 4; r++) begin
            test_frame("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       int'($urandom_range(1, 8)), 1'b0);
        end
        test_timeout();
        test_idle_wait();
        test_idle_send();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
